regfile_writeback_arbiter: RTL

- Shares the single register-file write port between N_REQ writeback requesters (ALU, load, mult/div) using round-robin arbitration over valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards (rs_busy/rt_busy).
- Sits between execute/memory writeback sources and the register file write port (rd, write_data, write_enable).

---
 rtl/regfile_writeback_arbiter_pkg.sv | 13 +
 rtl/regfile_writeback_arbiter_if.sv | 38 +++
 rtl/regfile_writeback_arbiter_rr_arbiter.sv | 36 +++
 rtl/regfile_writeback_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_writeback_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus: requester handshakes, issue/hazard ports and register-file write port.
interface regfile_writeback_arbiter_if
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) ();

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [REG_ADDR_W*N_REQ-1:0] req_rd;
  logic [DATA_W*N_REQ-1:0]     req_data;

  logic                        issue_valid;
  reg_addr_t                   issue_rd;
  logic                        issue_ready;

  reg_addr_t                   query_rs;
  reg_addr_t                   query_rt;
  logic                        rs_busy;
  logic                        rt_busy;

  reg_addr_t                   rf_rd;
  reg_data_t                   rf_write_data;
  logic                        rf_write_enable;

  // Driven by requesters, decode and the register file side.
  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, query_rs, query_rt,
    input  req_ready, issue_ready, rs_busy, rt_busy, rf_rd, rf_write_data, rf_write_enable
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, query_rs, query_rt,
    output req_ready, issue_ready, rs_busy, rt_busy, rf_rd, rf_write_data, rf_write_enable
  );

endinterface

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i (wrapping) wins.
module regfile_writeback_arbiter_rr_arbiter #(
  parameter int unsigned N    = 3,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] grant_idx_o,
  output logic            any_o
);

  // Scan from the pointer, wrapping once; the first hit is the only grant.
  always_comb begin
    logic [PtrW-1:0] idx;
    int unsigned     pos;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = '0;
    pos         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = PtrW'(pos);
      if (!any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register-file write port between N_REQ writeback sources and tracks
// pending writes per register so decode can stall on RAW hazards.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 2
) (
  input logic                         clock,
  input logic                         reset,
  regfile_writeback_arbiter_if.slave  bus
);

  localparam int unsigned         PtrW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0]    CntMax = {CNT_W{1'b1}};

  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [PtrW-1:0]  grant_idx;
  logic             grant_any;
  reg_addr_t        grant_rd;
  reg_data_t        grant_data;
  logic             grant_wr;

  logic             issue_ready;
  logic             issue_fire;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  reg_addr_t        rf_rd_q, rf_rd_d;
  reg_data_t        rf_data_q, rf_data_d;
  logic             rf_we_q, rf_we_d;

  // Requests are masked during reset so no handshake can complete.
  always_comb begin
    arb_req = reset ? '0 : bus.req_valid;
  end

  regfile_writeback_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req_i       (arb_req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Select the granted requester's destination and data (grant is one-hot).
  always_comb begin
    grant_rd   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_rd   = bus.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        grant_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_wr = grant_any && (grant_rd != REG_ZERO);
  end

  // A saturated counter still accepts an issue if a grant frees a slot this cycle.
  always_comb begin
    issue_ready = (cnt_q[bus.issue_rd] != CntMax) || (grant_any && (grant_rd == bus.issue_rd));
    issue_fire  = bus.issue_valid && issue_ready && (bus.issue_rd != REG_ZERO);
  end

  // Pending-write counters: increment on issue, decrement on grant, net zero if both.
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      inc      = issue_fire && (bus.issue_rd == REG_ADDR_W'(r));
      dec      = grant_wr && (grant_rd == REG_ADDR_W'(r));
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        // Underflow is a requester protocol error; hold at zero.
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Advance the round-robin pointer past the winner; registered write-port stage.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    rf_we_d   = 1'b0;
    if (grant_any) begin
      rr_ptr_d  = (grant_idx == PtrW'(N_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
      rf_rd_d   = grant_rd;
      rf_data_d = grant_data;
      rf_we_d   = grant_wr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      rf_we_q   <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      rf_we_q   <= rf_we_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Outputs; hazard flags come straight from the current counters.
  always_comb begin
    bus.req_ready       = grant;
    bus.issue_ready     = issue_ready;
    bus.rs_busy         = (cnt_q[bus.query_rs] != '0);
    bus.rt_busy         = (cnt_q[bus.query_rt] != '0);
    bus.rf_rd           = rf_rd_q;
    bus.rf_write_data   = rf_data_q;
    bus.rf_write_enable = rf_we_q;
  end

endmodule
